box_raster_engine: RTL and testbench

Pixel-stream responder for the box-move controller's draw/erase request interface. On a `go` request it captures a rectangle's origin, dimensions and colour. It then emits one VGA pixel per clock in raster order and returns a single-cycle `done` pulse when the rectangle is complete. It sits between the move/step control FSMs and the VGA controller, whose x, y, colour and plot ports it drives directly.

---
 rtl/box_raster_engine.sv | 108 ++++++++++
 tb/tb_box_raster_engine.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/box_raster_engine.sv
// Box raster engine: streams one VGA pixel per clock for a captured rectangle.
// Ports: iClock/iResetn, request (iGo,iErase,iColour,iX,iY,iXDim,iYDim), VGA (oX,oY,oColour,oPlot), status (oDone,oBusy).
module box_raster_engine #(
  parameter int X_SCREEN_PIXELS = 160,
  parameter int Y_SCREEN_PIXELS = 120,
  parameter logic [5:0] ERASE_COLOUR = 6'd0
) (
  input  logic       iClock,
  input  logic       iResetn,
  input  logic       iGo,
  input  logic       iErase,
  input  logic [5:0] iColour,
  input  logic [7:0] iX,
  input  logic [6:0] iY,
  input  logic [7:0] iXDim,
  input  logic [7:0] iYDim,
  output logic [7:0] oX,
  output logic [6:0] oY,
  output logic [5:0] oColour,
  output logic       oPlot,
  output logic       oDone,
  output logic       oBusy
);

  localparam logic [8:0] XLIM = 9'(X_SCREEN_PIXELS);
  localparam logic [8:0] YLIM = 9'(Y_SCREEN_PIXELS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLOT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] bx;
  logic [6:0] by;
  logic [7:0] w;
  logic [7:0] h;
  logic [5:0] col;
  logic [7:0] xo;
  logic [7:0] yo;

  logic       x_last;
  logic       y_last;
  logic [8:0] sx;
  logic [8:0] sy;

  assign x_last = (xo == w - 8'd1);
  assign y_last = (yo == h - 8'd1);

  // Full 9-bit sums so clipped pixels never wrap back on screen.
  assign sx = {1'b0, bx} + {1'b0, xo};
  assign sy = {2'b0, by} + {1'b0, yo};

  always_ff @(posedge iClock) begin
    if (!iResetn) begin
      state <= IDLE;
      bx    <= '0;
      by    <= '0;
      w     <= '0;
      h     <= '0;
      col   <= '0;
      xo    <= '0;
      yo    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (iGo) begin
            bx  <= iX;
            by  <= iY;
            w   <= iXDim;
            h   <= iYDim;
            col <= iErase ? ERASE_COLOUR : iColour;
            xo  <= '0;
            yo  <= '0;
            if (iXDim == 8'd0 || iYDim == 8'd0)
              state <= DONE;
            else
              state <= PLOT;
          end
        end
        PLOT: begin
          if (x_last) begin
            xo <= '0;
            yo <= yo + 8'd1;
          end else begin
            xo <= xo + 8'd1;
          end
          // Completion beats an abort on the same edge.
          if (x_last && y_last)
            state <= DONE;
          else if (!iGo)
            state <= IDLE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign oX      = sx[7:0];
  assign oY      = sy[6:0];
  assign oColour = col;
  assign oBusy   = (state == PLOT);
  assign oDone   = (state == DONE);
  assign oPlot   = (state == PLOT) && (sx < XLIM) && (sy < YLIM);

endmodule

// File: tb/tb_box_raster_engine.sv
// Self-checking bench for box_raster_engine: directed cases plus random requests
// compared against a per-cycle raster model of the rectangle.
module tb_box_raster_engine;

  logic       iClock = 1'b0;
  logic       iResetn = 1'b0;
  logic       iGo = 1'b0;
  logic       iErase = 1'b0;
  logic [5:0] iColour = '0;
  logic [7:0] iX = '0;
  logic [6:0] iY = '0;
  logic [7:0] iXDim = '0;
  logic [7:0] iYDim = '0;
  logic [7:0] oX;
  logic [6:0] oY;
  logic [5:0] oColour;
  logic       oPlot;
  logic       oDone;
  logic       oBusy;

  int n_chk = 0;
  int n_fail = 0;

  box_raster_engine dut (
    .iClock (iClock),
    .iResetn(iResetn),
    .iGo    (iGo),
    .iErase (iErase),
    .iColour(iColour),
    .iX     (iX),
    .iY     (iY),
    .iXDim  (iXDim),
    .iYDim  (iYDim),
    .oX     (oX),
    .oY     (oY),
    .oColour(oColour),
    .oPlot  (oPlot),
    .oDone  (oDone),
    .oBusy  (oBusy)
  );

  always #5 iClock = ~iClock;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_plot"}, int'(oPlot), 0);
    chk({tag, "_busy"}, int'(oBusy), 0);
    chk({tag, "_done"}, int'(oDone), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk_quiet(tag);
    chk({tag, "_x"}, int'(oX), 0);
    chk({tag, "_y"}, int'(oY), 0);
    chk({tag, "_col"}, int'(oColour), 0);
  endtask

  // abort_at / rst_at: pixel cycle after which iGo drops / reset asserts (0 = never).
  task automatic do_req(input int x, input int y, input int xd, input int yd,
                        input int col, input bit er,
                        input int abort_at, input int rst_at);
    int total;
    int ecol;
    int px;
    int py;
    bit ep;
    total = xd * yd;
    ecol = er ? 0 : col;
    @(negedge iClock);
    iGo = 1'b1;
    iX = 8'(x);
    iY = 7'(y);
    iXDim = 8'(xd);
    iYDim = 8'(yd);
    iColour = 6'(col);
    iErase = er;
    for (int k = 1; k <= total + 1; k++) begin
      @(negedge iClock);
      if (k == 1) begin
        iX = 8'($urandom);
        iY = 7'($urandom);
        iXDim = 8'($urandom);
        iYDim = 8'($urandom);
        iColour = 6'($urandom);
        iErase = 1'($urandom);
      end
      if (k <= total) begin
        px = x + (k - 1) % xd;
        py = y + (k - 1) / xd;
        ep = (px < 160) && (py < 120);
        chk("busy", int'(oBusy), 1);
        chk("done_early", int'(oDone), 0);
        chk("plot", int'(oPlot), int'(ep));
        if (ep) begin
          chk("px", int'(oX), px);
          chk("py", int'(oY), py);
          chk("pcol", int'(oColour), ecol);
        end
        if (rst_at == k) begin
          iResetn = 1'b0;
          @(negedge iClock);
          chk_zero("rst");
          iResetn = 1'b1;
          iGo = 1'b0;
          @(negedge iClock);
          chk_quiet("rst_idle");
          return;
        end
        if (abort_at == k) begin
          iGo = 1'b0;
          if (k < total) begin
            @(negedge iClock);
            chk_quiet("abort");
            @(negedge iClock);
            chk_quiet("abort_idle");
            return;
          end
        end
      end else begin
        chk("done", int'(oDone), 1);
        chk("done_busy", int'(oBusy), 0);
        chk("done_plot", int'(oPlot), 0);
        iGo = 1'b0;
      end
    end
    @(negedge iClock);
    chk_quiet("idle");
  endtask

  initial begin
    int x, y, xd, yd, ab, rs;
    repeat (3) @(negedge iClock);
    chk_zero("reset");
    iResetn = 1'b1;
    @(negedge iClock);
    chk_zero("reset_idle");

    do_req(10, 20, 4, 4, 'h2A, 1'b0, 0, 0);
    do_req(10, 20, 4, 4, 'h3F, 1'b1, 0, 0);
    do_req(158, 118, 4, 4, 'h11, 1'b0, 0, 0);
    do_req(5, 5, 0, 5, 'h07, 1'b0, 0, 0);
    do_req(5, 5, 3, 0, 'h07, 1'b0, 0, 0);
    do_req(30, 40, 8, 8, 'h15, 1'b0, 10, 0);
    do_req(1, 2, 2, 2, 'h2B, 1'b0, 0, 0);
    do_req(50, 60, 3, 2, 'h09, 1'b0, 6, 0);
    do_req(20, 30, 4, 4, 'h1C, 1'b0, 0, 5);
    do_req(100, 100, 3, 3, 'h33, 1'b0, 0, 0);
    do_req(255, 127, 2, 2, 'h01, 1'b0, 0, 0);

    for (int r = 0; r < 60; r++) begin
      x = int'($urandom_range(0, 255));
      y = int'($urandom_range(0, 127));
      xd = int'($urandom_range(0, 12));
      yd = int'($urandom_range(0, 8));
      ab = 0;
      rs = 0;
      if (xd * yd > 0) begin
        if ($urandom_range(0, 4) == 0)
          ab = int'($urandom_range(1, xd * yd));
        else if ($urandom_range(0, 9) == 0)
          rs = int'($urandom_range(1, xd * yd));
      end
      do_req(x, y, xd, yd, int'($urandom_range(0, 63)),
             1'($urandom), ab, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
